reg_bus_sequencer: RTL and testbench

Sequences register-to-register transfers over the shared 8-bit CPU bus. It drives the `enable` (bus output) and `set` (latch) lines of up to NUM_REGS 8-bit CPU registers. Transfer requests (source index, destination index) arrive over a valid/ready handshake and are buffered in a 2-entry queue. Each transfer runs a fixed three-phase sequence, so exactly one register drives the bus and `set` is only asserted while the bus is stable.

---
 rtl/cpu_bus_pkg.sv | 26 ++
 rtl/req_fifo_2.sv | 49 ++++
 rtl/reg_bus_sequencer.sv | 120 ++++++++++++
 tb/tb_reg_bus_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU register bus sequencer.
// State encoding, request record and bus width.
package cpu_bus_pkg;

    localparam int BUS_W     = 8;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        LATCH,
        RELEASE,
        ERR
    } state_t;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] src;
        logic [MAX_IDX_W-1:0] dst;
    } req_t;

    // A transfer needs two distinct, in-range registers.
    function automatic logic req_ok(input req_t r, input int n);
        return (r.src != r.dst) && (int'(r.src) < n) && (int'(r.dst) < n);
    endfunction

endpackage

// File: rtl/req_fifo_2.sv
// Two-entry request FIFO with asynchronous clear.
// Push is ignored when full, pop is ignored when empty.
module req_fifo_2
    import cpu_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  req_t din,
    output req_t dout,
    output logic full,
    output logic empty
);

    req_t       mem [2];
    logic       wp;
    logic       rp;
    logic [1:0] cnt;
    logic       do_push;
    logic       do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    // Storage, pointers and occupancy; push and pop may share an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (do_pop) begin
                rp <= ~rp;
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Sequences register-to-register moves on the shared CPU bus.
// Each move is DRIVE, LATCH, RELEASE; bad requests take one ERR cycle.
module reg_bus_sequencer
    import cpu_bus_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_src,
    input  logic [IDX_W-1:0]    req_dst,
    output logic [NUM_REGS-1:0] reg_enable,
    output logic [NUM_REGS-1:0] reg_set,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t state;
    state_t state_d;
    req_t   cur_q;
    req_t   in_req;
    req_t   head;
    logic   full;
    logic   empty;
    logic   pop;

    assign in_req.src = MAX_IDX_W'(req_src);
    assign in_req.dst = MAX_IDX_W'(req_dst);

    assign req_ready = !full;
    assign busy      = (state != IDLE) || !empty;

    req_fifo_2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .pop   (pop),
        .din   (in_req),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    function automatic logic [NUM_REGS-1:0] onehot(
        input logic [MAX_IDX_W-1:0] i
    );
        logic [NUM_REGS-1:0] v;
        for (int k = 0; k < NUM_REGS; k++) begin
            v[k] = (int'(i) == k);
        end
        return v;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Latch the popped request so the decode sees only flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q <= '0;
        end else if (pop) begin
            cur_q <= head;
        end
    end

    // Next state and pop; RELEASE and ERR chain straight into the next move.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        unique case (state)
            DRIVE:   state_d = LATCH;
            LATCH:   state_d = RELEASE;
            default: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = req_ok(head, NUM_REGS) ? DRIVE : ERR;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Bus line decode from state and latched indices only.
    always_comb begin
        reg_enable = '0;
        reg_set    = '0;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state)
            DRIVE: begin
                reg_enable = onehot(cur_q.src);
            end
            LATCH: begin
                reg_enable = onehot(cur_q.src);
                reg_set    = onehot(cur_q.dst);
            end
            RELEASE: begin
                reg_enable = onehot(cur_q.src);
                done       = 1'b1;
            end
            ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: timeline model plus directed cases.
// Includes a small register file hanging off the shared bus.
module tb_reg_bus_sequencer;
    import cpu_bus_pkg::*;

    localparam int T = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0;
    logic [1:0] req_src   = '0;
    logic [1:0] req_dst   = '0;
    logic       req_ready;
    logic [3:0] reg_enable;
    logic [3:0] reg_set;
    logic       busy;
    logic       done;
    logic       err;

    logic       v3 = 1'b0;
    logic [2:0] s3 = '0;
    logic [2:0] d3 = '0;
    logic       rdy3;
    logic [3:0] en3;
    logic [3:0] set3;
    logic       busy3;
    logic       done3;
    logic       err3;

    reg_bus_sequencer #(.NUM_REGS(4), .IDX_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .reg_enable (reg_enable),
        .reg_set    (reg_set),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    reg_bus_sequencer #(.NUM_REGS(4), .IDX_W(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (v3),
        .req_ready  (rdy3),
        .req_src    (s3),
        .req_dst    (d3),
        .reg_enable (en3),
        .reg_set    (set3),
        .busy       (busy3),
        .done       (done3),
        .err        (err3)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", n, cyc, a, e);
        end
    endtask

    // Timeline model: each accepted request owns a span of cycles.
    typedef struct {
        int acc;
        int start;
        int last;
    } ent_t;

    ent_t       ents [$];
    int         free_c = 0;
    logic [3:0] m_en   [T];
    logic [3:0] m_set  [T];
    bit         m_done [T];
    bit         m_err  [T];

    function automatic int occ(input int c);
        int n = 0;
        foreach (ents[i]) if (ents[i].acc <= c && ents[i].start > c) n++;
        return n;
    endfunction

    function automatic bit mbusy(input int c);
        foreach (ents[i]) if (ents[i].acc <= c && c <= ents[i].last) return 1;
        return 0;
    endfunction

    function automatic void schedule(input int e, input int s, input int d);
        ent_t x;
        x.acc   = e;
        x.start = (e + 1 > free_c) ? e + 1 : free_c;
        if (s != d) begin
            for (int k = 0; k < 3; k++) m_en[x.start + k] = 4'(1 << s);
            m_set[x.start + 1]  = 4'(1 << d);
            m_done[x.start + 2] = 1'b1;
            x.last = x.start + 2;
        end else begin
            m_done[x.start] = 1'b1;
            m_err[x.start]  = 1'b1;
            x.last = x.start;
        end
        free_c = x.last + 1;
        ents.push_back(x);
    endfunction

    always @(posedge clk) begin
        int e;
        e = cyc + 1;
        if (!rst && req_valid && occ(cyc) < 2 && e + 4 < T)
            schedule(e, int'(req_src), int'(req_dst));
        cyc = e;
    end

    always @(posedge rst) begin
        ents.delete();
        free_c = 0;
        for (int c = cyc; c < T; c++) begin
            m_en[c]   = '0;
            m_set[c]  = '0;
            m_done[c] = 1'b0;
            m_err[c]  = 1'b0;
        end
    end

    // Per-cycle log of DUT outputs for the directed checks.
    logic [3:0] lg_en   [T];
    logic [3:0] lg_set  [T];
    bit         lg_done [T];
    bit         lg_err  [T];
    bit         lg_rdy  [T];
    bit         lg3_done[T];
    bit         lg3_err [T];
    logic [3:0] lg3_en  [T];
    bit         set3_seen = 1'b0;

    // Compare every cycle against the model.
    always @(negedge clk) begin
        if (cyc < T) begin
            chk("enable", 32'(reg_enable), 32'(m_en[cyc]));
            chk("set",    32'(reg_set),    32'(m_set[cyc]));
            chk("done",   32'(done),       32'(m_done[cyc]));
            chk("err",    32'(err),        32'(m_err[cyc]));
            chk("ready",  32'(req_ready),  32'(occ(cyc) < 2));
            chk("busy",   32'(busy),       32'(mbusy(cyc)));
            lg_en[cyc]    = reg_enable;
            lg_set[cyc]   = reg_set;
            lg_done[cyc]  = done;
            lg_err[cyc]   = err;
            lg_rdy[cyc]   = req_ready;
            lg3_done[cyc] = done3;
            lg3_err[cyc]  = err3;
            lg3_en[cyc]   = en3;
            if (set3 != 4'b0) set3_seen = 1'b1;
        end
    end

    // Four bus registers latching on their set line.
    logic [BUS_W-1:0] regs [4];
    logic [BUS_W-1:0] bus;
    always @* begin
        bus = '0;
        for (int i = 0; i < 4; i++) if (reg_enable[i]) bus = regs[i];
    end
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (reg_set[i]) regs[i] <= bus;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] s, input logic [1:0] d,
                        output int acc);
        req_src   = s;
        req_dst   = d;
        req_valid = 1'b1;
        acc       = -1;
        for (int k = 0; k < 30; k++) begin
            bit r;
            r = (occ(cyc) < 2);
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                break;
            end
        end
        req_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept");
            acc = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a0, a1, a2, a3, cnt;
        tick(3);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy",  32'(busy),      32'd0);
        rst = 1'b0;
        tick(1);

        // Single move 0 -> 2.
        send(2'd0, 2'd2, n);
        tick(6);
        chk("t1_en1",   32'(lg_en[n+1]),  32'h1);
        chk("t1_set1",  32'(lg_set[n+1]), 32'h0);
        chk("t1_en2",   32'(lg_en[n+2]),  32'h1);
        chk("t1_set2",  32'(lg_set[n+2]), 32'h4);
        chk("t1_en3",   32'(lg_en[n+3]),  32'h1);
        chk("t1_done3", 32'(lg_done[n+3]), 32'd1);
        chk("t1_err3",  32'(lg_err[n+3]),  32'd0);
        chk("t1_idle4", 32'(lg_en[n+4]),  32'h0);

        // Burst of four; the queue fills and stalls the last one.
        send(2'd1, 2'd3, a0);
        send(2'd3, 2'd0, a1);
        send(2'd2, 2'd1, a2);
        send(2'd0, 2'd2, a3);
        tick(16);
        chk("b_acc1", 32'(a1 - a0), 32'd1);
        chk("b_acc2", 32'(a2 - a0), 32'd2);
        chk("b_full", 32'(lg_rdy[a0+2]), 32'd0);
        chk("b_acc3", 32'(a3 - a0), 32'd5);
        chk("b_set2", 32'(lg_set[a0+5]), 32'h1);
        chk("b_en3",  32'(lg_en[a0+7]),  32'h4);
        cnt = 0;
        for (int c = a0; c < a0 + 16; c++) cnt += int'(lg_done[c]);
        chk("b_dones", 32'(cnt), 32'd4);
        for (int k = 1; k <= 4; k++)
            chk("b_done_at", 32'(lg_done[a0 + 3*k]), 32'd1);

        // Same-index request then a good one.
        send(2'd2, 2'd2, a0);
        send(2'd0, 2'd1, a1);
        tick(6);
        chk("e_done", 32'(lg_done[a0+1]), 32'd1);
        chk("e_err",  32'(lg_err[a0+1]),  32'd1);
        chk("e_en",   32'(lg_en[a0+1]),   32'h0);
        chk("e_set",  32'(lg_set[a0+1]),  32'h0);
        chk("e_next", 32'(lg_en[a0+2]),   32'h1);

        // Out-of-range destination on the 3-bit index build.
        v3 = 1'b1;
        s3 = 3'd0;
        d3 = 3'd5;
        tick(1);
        n  = cyc;
        v3 = 1'b0;
        tick(4);
        chk("r_done", 32'(lg3_done[n+1]), 32'd1);
        chk("r_err",  32'(lg3_err[n+1]),  32'd1);
        chk("r_en",   32'(lg3_en[n+1]),   32'h0);
        chk("r_set",  32'(set3_seen),     32'd0);

        // Reset during LATCH with one request still queued.
        send(2'd1, 2'd3, a0);
        send(2'd0, 2'd1, a1);
        tick(1);
        chk("x_latch", 32'(reg_set), 32'h8);
        #2;
        rst = 1'b1;
        #1;
        chk("x_en",    32'(reg_enable), 32'h0);
        chk("x_set",   32'(reg_set),    32'h0);
        chk("x_done",  32'(done),       32'd0);
        chk("x_ready", 32'(req_ready),  32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(8);
        cnt = 0;
        for (int c = a0 + 2; c < a0 + 11; c++)
            cnt += int'(lg_done[c]) + int'(lg_en[c] != 0);
        chk("x_quiet", 32'(cnt), 32'd0);

        // Shared-bus integration.
        regs[0] = 8'hAA;
        regs[1] = 8'h55;
        regs[2] = 8'h34;
        regs[3] = 8'h00;
        send(2'd0, 2'd3, n);
        send(2'd2, 2'd0, n);
        tick(10);
        chk("i_r0", 32'(regs[0]), 32'h34);
        chk("i_r1", 32'(regs[1]), 32'h55);
        chk("i_r2", 32'(regs[2]), 32'h34);
        chk("i_r3", 32'(regs[3]), 32'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
